i2s_decoder: RTL and testbench

- Receives a standard Philips I2S stream (BCLK, LRCLK, SDATA) from an external source and recovers parallel stereo PCM samples.
- It is the receive-side counterpart of the I2S encoder.
- All I2S pins are oversampled in a single fast system clock domain. Edges are detected internally, so BCLK is never used as a clock.
- Its output feeds any block that consumes parallel stereo words, such as a loopback checker or a sample-rate monitor.

---
 rtl/i2s_decoder.sv | 177 +++++++++++++++++
 tb/tb_i2s_decoder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_decoder.sv
// i2s_decoder: recovers parallel stereo PCM words from a Philips I2S stream.
// BCLK, LRCLK and SDATA are oversampled in the i_clk domain. BCLK edges are
// detected in logic, so BCLK is never used as a clock.
//
// Ports:
//   i_clk        system clock, at least 4x BCLK
//   i_rst        synchronous active-high reset
//   i_i2s_bclk   I2S bit clock (asynchronous)
//   i_i2s_lrclk  I2S word select, 0 = left, 1 = right (asynchronous)
//   i_i2s_sdata  I2S serial data, MSB first (asynchronous)
//   o_data_l     last complete left sample of a coherent L/R pair
//   o_data_r     last complete right sample of a coherent L/R pair
//   o_valid      one-cycle pulse when o_data_l/o_data_r are updated
//   o_short      one-cycle pulse when a slot ends with fewer than WIDTH bits
//   o_locked     high once the first LRCLK transition has been seen
module i2s_decoder #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_i2s_bclk,
  input  logic             i_i2s_lrclk,
  input  logic             i_i2s_sdata,
  output logic [WIDTH-1:0] o_data_l,
  output logic [WIDTH-1:0] o_data_r,
  output logic             o_valid,
  output logic             o_short,
  output logic             o_locked
);

  localparam int unsigned    CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  // Synchronizer chains: identical depth keeps the three pins aligned.
  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrclk_sync_q;
  logic [SYNC_STAGES-1:0] sdata_sync_q;
  logic                   bclk_prev_q;

  // Capture state.
  state_e           state_q;
  logic             lr_seen_q;
  logic             lr_last_q;
  logic             ch_q;
  logic             have_l_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] hold_l_q;

  // Registered outputs.
  logic [WIDTH-1:0] data_l_q;
  logic [WIDTH-1:0] data_r_q;
  logic             valid_q;
  logic             short_q;
  logic             locked_q;

  logic             bclk_s;
  logic             lrclk_s;
  logic             sdata_s;
  logic             rise_c;
  logic             in_lock_c;
  logic             boundary_c;
  logic             complete_c;
  logic             short_c;
  logic [WIDTH-1:0] sh_d;

  assign bclk_s  = bclk_sync_q[SYNC_STAGES-1];
  assign lrclk_s = lrclk_sync_q[SYNC_STAGES-1];
  assign sdata_s = sdata_sync_q[SYNC_STAGES-1];

  // Rising edge of the synchronized bit clock; all capture advances here.
  assign rise_c     = bclk_s & ~bclk_prev_q;
  assign in_lock_c  = (state_q == ST_LOCKED);
  assign boundary_c = (lrclk_s != ch_q);

  // Shift register with the current bit appended at the LSB.
  assign sh_d = WIDTH'({sh_q, sdata_s});

  // The WIDTH-th bit completes a word whether it arrives inside the slot or
  // on the boundary rise (the I2S one-bit delay puts the LSB there at 32fs).
  assign complete_c = in_lock_c & rise_c & (cnt_q == CNT_LAST);

  // A boundary reached before WIDTH-1 bits leaves a truncated word.
  assign short_c = in_lock_c & rise_c & boundary_c & (cnt_q < CNT_LAST);

  // Synchronizer, capture FSM and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
      bclk_prev_q  <= 1'b0;
      state_q      <= ST_UNLOCKED;
      lr_seen_q    <= 1'b0;
      lr_last_q    <= 1'b0;
      ch_q         <= 1'b0;
      have_l_q     <= 1'b0;
      cnt_q        <= '0;
      sh_q         <= '0;
      hold_l_q     <= '0;
      data_l_q     <= '0;
      data_r_q     <= '0;
      valid_q      <= 1'b0;
      short_q      <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], i_i2s_bclk};
      lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], i_i2s_lrclk};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], i_i2s_sdata};
      bclk_prev_q  <= bclk_s;
      valid_q      <= 1'b0;
      short_q      <= short_c;

      if (rise_c) begin
        case (state_q)
          ST_UNLOCKED: begin
            // Wait for a genuine LRCLK transition so a stream entered
            // mid-slot never yields a partial word.
            lr_seen_q <= 1'b1;
            lr_last_q <= lrclk_s;
            if (lr_seen_q && (lrclk_s != lr_last_q)) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              ch_q     <= lrclk_s;
              cnt_q    <= '0;
              sh_q     <= '0;
              have_l_q <= 1'b0;
            end
          end

          ST_LOCKED: begin
            if (boundary_c) begin
              ch_q  <= lrclk_s;
              cnt_q <= '0;
              sh_q  <= '0;
              // A truncated left word breaks the L/R pairing.
              if (short_c && !ch_q) begin
                have_l_q <= 1'b0;
              end
            end else if (cnt_q < CNT_FULL) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_q + CNT_ONE;
            end

            if (complete_c) begin
              if (!ch_q) begin
                hold_l_q <= sh_d;
                have_l_q <= 1'b1;
              end else if (have_l_q) begin
                // Publish both channels together as one coherent frame.
                data_l_q <= hold_l_q;
                data_r_q <= sh_d;
                valid_q  <= 1'b1;
                have_l_q <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  assign o_data_l = data_l_q;
  assign o_data_r = data_r_q;
  assign o_valid  = valid_q;
  assign o_short  = short_q;
  assign o_locked = locked_q;

endmodule

// File: tb/tb_i2s_decoder.sv
// tb_i2s_decoder: drives I2S frames (directed plus randomized) into
// i2s_decoder and compares every output on every cycle with a word-level
// model, plus literal expectations for the directed frames.
module tb_i2s_decoder;

  localparam int WIDTH = 16;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;
  localparam int MAXC  = 65536;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             bclk;
  logic             lrclk;
  logic             sdata;
  logic [WIDTH-1:0] o_data_l;
  logic [WIDTH-1:0] o_data_r;
  logic             o_valid;
  logic             o_short;
  logic             o_locked;

  i2s_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_i2s_bclk (bclk),
    .i_i2s_lrclk(lrclk),
    .i_i2s_sdata(sdata),
    .o_data_l   (o_data_l),
    .o_data_r   (o_data_r),
    .o_valid    (o_valid),
    .o_short    (o_short),
    .o_locked   (o_locked)
  );

  always #5 i_clk = ~i_clk;

  // Per-edge history: reset level at each edge, and BCLK rises driven after it.
  int cyc = 0;
  bit rst_at [MAXC];
  bit rise_at[MAXC];
  bit rlr    [MAXC];
  bit rsd    [MAXC];

  int n_checks = 0;
  int n_errors = 0;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (cyc + 1 < MAXC) rst_at[cyc + 1] <= i_rst;
  end

  // Word-level reference model.
  bit               m_locked, m_seen, m_rec, m_ch, m_have, m_v, m_s;
  logic [WIDTH-1:0] m_hold, m_l, m_r;
  bit               slotq[$];

  // Observed pulses, consumed by the directed checks.
  logic [WIDTH-1:0] dq_l[$], dq_r[$], mq_l[$], mq_r[$];
  int               d_short = 0;

  function automatic void model_reset();
    m_locked = 0; m_seen = 0; m_rec = 0; m_ch = 0; m_have = 0;
    m_hold = '0; m_l = '0; m_r = '0;
    slotq.delete();
  endfunction

  function automatic void model_complete();
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < WIDTH; i++) w = {w[WIDTH-2:0], slotq[i]};
    if (!m_ch) begin
      m_hold = w;
      m_have = 1;
    end else if (m_have) begin
      m_l = m_hold;
      m_r = w;
      m_v = 1;
      m_have = 0;
      mq_l.push_back(m_hold);
      mq_r.push_back(w);
    end
  endfunction

  // One bit as seen by the receiver: the first WIDTH bits of a slot
  // (including the LSB carried on the boundary) form the word.
  function automatic void model_bit(input bit lr, input bit sd);
    if (!m_locked) begin
      if (m_seen && lr != m_rec) begin
        m_locked = 1;
        m_ch = lr;
        m_have = 0;
        slotq.delete();
      end
      m_seen = 1;
      m_rec = lr;
    end else begin
      if (slotq.size() <= WIDTH) begin
        slotq.push_back(sd);
        if (slotq.size() == WIDTH) model_complete();
      end
      if (lr != m_ch) begin
        if (slotq.size() < WIDTH) begin
          m_s = 1;
          if (!m_ch) m_have = 0;
        end
        slotq.delete();
        m_ch = lr;
      end
    end
  endfunction

  // Per-cycle compare: a pin rise driven after edge n reaches the capture
  // logic at edge n+LAT, unless a reset edge lies in between.
  always @(negedge i_clk) begin
    bit ok;
    if (cyc >= 1 && cyc < MAXC) begin
      m_v = 0;
      m_s = 0;
      if (rst_at[cyc]) begin
        model_reset();
      end else if (cyc > LAT && rise_at[cyc-LAT]) begin
        ok = 1;
        for (int k = 1; k < LAT; k++) if (rst_at[cyc-LAT+k]) ok = 0;
        if (ok) model_bit(rlr[cyc-LAT], rsd[cyc-LAT]);
      end
      n_checks++;
      if ({o_data_l, o_data_r, o_valid, o_short, o_locked} !==
          {m_l, m_r, m_v, m_s, m_locked}) begin
        n_errors++;
        $display("FAIL cycle %0d outputs: got l=%h r=%h v=%b s=%b lk=%b expected l=%h r=%h v=%b s=%b lk=%b",
                 cyc, o_data_l, o_data_r, o_valid, o_short, o_locked,
                 m_l, m_r, m_v, m_s, m_locked);
      end
      if (o_valid === 1'b1) begin
        dq_l.push_back(o_data_l);
        dq_r.push_back(o_data_r);
      end
      if (o_short === 1'b1) d_short++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Stimulus: per-BCLK queues; SDATA lags LRCLK by one bit (I2S delay).
  logic lrq[$], sdq[$];
  int   half = 4;
  bit   rel_pending = 0;

  task automatic set_pins(input logic b, input logic lr, input logic sd);
    if (b && !bclk && cyc < MAXC) begin
      rise_at[cyc] = 1;
      rlr[cyc] = lr;
      rsd[cyc] = sd;
    end
    bclk = b;
    lrclk = lr;
    sdata = sd;
  endtask

  task automatic restart_stream();
    lrq.delete();
    sdq.delete();
    sdq.push_back(1'($urandom));
  endtask

  task automatic add_slot(input logic lr, input logic [31:0] data, input int slen);
    for (int i = 0; i < slen; i++) begin
      lrq.push_back(lr);
      if (i < WIDTH) sdq.push_back(data[WIDTH-1-i]);
      else sdq.push_back(1'($urandom));
    end
  endtask

  task automatic period(input logic lr, input logic sd);
    set_pins(1'b0, lr, sd);
    if (rel_pending) begin
      i_rst = 1'b0;
      rel_pending = 0;
    end
    repeat (half) @(negedge i_clk);
    set_pins(1'b1, lr, sd);
    repeat (half) @(negedge i_clk);
  endtask

  task automatic play_n(input int n);
    for (int i = 0; i < n && lrq.size() > 0 && sdq.size() > 0; i++)
      period(lrq.pop_front(), sdq.pop_front());
  endtask

  task automatic play_all();
    while (lrq.size() > 0 && sdq.size() > 0) period(lrq.pop_front(), sdq.pop_front());
  endtask

  task automatic settle();
    repeat (8) @(negedge i_clk);
  endtask

  // Reset with pins toggling; released with BCLK low.
  task automatic rst_pulse(input int n);
    i_rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      set_pins(1'((k >> 1) & 1), 1'($urandom), 1'($urandom));
      @(negedge i_clk);
    end
    set_pins(1'b0, lrclk, sdata);
    @(negedge i_clk);
    i_rst = 1'b0;
    restart_stream();
    @(negedge i_clk);
  endtask

  task automatic expect_pairs(input string nm, input int nexp, input logic [31:0] p0,
                              input logic [31:0] p1, input int nshort);
    logic [31:0] pr[2];
    pr[0] = p0;
    pr[1] = p1;
    chk({nm, "_valid_count"}, 32'(dq_l.size()), 32'(nexp));
    chk({nm, "_model_valid_count"}, 32'(mq_l.size()), 32'(nexp));
    chk({nm, "_short_count"}, 32'(d_short), 32'(nshort));
    for (int i = 0; i < nexp && i < 2; i++) begin
      if (i < dq_l.size()) chk($sformatf("%s_pair%0d", nm, i), {dq_l[i], dq_r[i]}, pr[i]);
      if (i < mq_l.size()) chk($sformatf("%s_model_pair%0d", nm, i), {mq_l[i], mq_r[i]}, pr[i]);
    end
    dq_l.delete(); dq_r.delete(); mq_l.delete(); mq_r.delete();
    d_short = 0;
  endtask

  initial begin
    int slen, len_l, len_r;
    i_rst = 1'b1;
    bclk = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    restart_stream();
    @(negedge i_clk);

    // Reset with the stream toggling.
    rst_pulse(4);
    chk("rst_locked", 32'(o_locked), 32'h0);
    chk("rst_data", {o_data_l, o_data_r}, 32'h0);
    chk("rst_pulses", 32'({o_valid, o_short}), 32'h0);

    // 64fs, 8x oversampling.
    half = 4;
    add_slot(1'b1, $urandom, 32);
    add_slot(1'b0, 32'h1234, 32);
    add_slot(1'b1, 32'hABCD, 32);
    play_all();
    settle();
    expect_pairs("fs64", 1, 32'h1234ABCD, 32'h0, 0);
    chk("fs64_locked", 32'(o_locked), 32'h1);

    // 32fs exact fit, 4x oversampling.
    half = 2;
    add_slot(1'b0, 32'h8000, 16);
    add_slot(1'b1, 32'h7FFF, 16);
    add_slot(1'b0, 32'hFFFF, 16);
    add_slot(1'b1, 32'h0001, 16);
    add_slot(1'b0, $urandom, 16);
    play_all();
    settle();
    expect_pairs("fs32", 2, 32'h80007FFF, 32'hFFFF0001, 0);
    half = 4;

    // Reset released halfway through a right slot.
    i_rst = 1'b1;
    restart_stream();
    add_slot(1'b1, $urandom, 32);
    play_n(16);
    rel_pending = 1;
    add_slot(1'b0, 32'h5555, 32);
    add_slot(1'b1, 32'hAAAA, 32);
    play_all();
    settle();
    expect_pairs("midslot", 1, 32'h5555AAAA, 32'h0, 0);

    // Short left slot, then a right word that has no partner.
    add_slot(1'b0, $urandom, 10);
    add_slot(1'b1, 32'h0F0F, 32);
    play_all();
    settle();
    expect_pairs("short", 0, 32'h0, 32'h0, 1);
    chk("short_hold", {o_data_l, o_data_r}, 32'h5555AAAA);
    add_slot(1'b0, 32'h1111, 32);
    add_slot(1'b1, 32'h2222, 32);
    play_all();
    settle();
    expect_pairs("after_short", 1, 32'h11112222, 32'h0, 0);

    // Reset after 8 bits of a right slot, then re-lock.
    add_slot(1'b0, 32'h3333, 32);
    add_slot(1'b1, 32'h4321, 32);
    play_n(32 + 9);
    rst_pulse(4);
    chk("midword_rst_locked", 32'(o_locked), 32'h0);
    chk("midword_rst_data", {o_data_l, o_data_r}, 32'h0);
    expect_pairs("midword_pre", 0, 32'h0, 32'h0, 0);
    add_slot(1'b0, $urandom, 32);
    add_slot(1'b1, $urandom, 32);
    add_slot(1'b0, 32'h4444, 32);
    add_slot(1'b1, 32'h5A5A, 32);
    play_all();
    settle();
    expect_pairs("relock", 1, 32'h44445A5A, 32'h0, 0);

    // Randomized frames: mixed slot sizes, short slots, resets, BCLK rates.
    for (int f = 0; f < 40; f++) begin
      half = $urandom_range(2, 4);
      if ($urandom_range(0, 14) == 0) rst_pulse($urandom_range(2, 6));
      case ($urandom_range(0, 2))
        0: slen = 16;
        1: slen = 24;
        default: slen = 32;
      endcase
      len_l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : slen;
      len_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : slen;
      add_slot(1'b0, $urandom, len_l);
      add_slot(1'b1, $urandom, len_r);
      play_all();
    end
    settle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
